sw_input_periph: RTL and testbench
==================================

Name: sw_input_periph

Overview:
Memory-mapped switch-input responder on the CPU data bus; the read-side counterpart to the LED/seven-segment write outputs.
- Synchronises and debounces the board switch inputs.
- Records sticky rising/falling edge flags and exposes them through four word registers.
- Sits beside the memory system: the memory system decodes the address range and drives sel_in; read data returns with one-cycle latency, matching the RAM.

Parameters:
NUM_SW, 16, number of switch inputs (1..32)
TICK_DIV, 2000, sys_clk cycles per debounce sample tick (10 us at 200 MHz); >= 2
DEBOUNCE_TICKS, 500, consecutive ticks a changed input must hold before acceptance (5 ms); >= 1

Ports:
clk_in  input  1  system clock; all logic in this single domain
rst_in  input  1  asynchronous, active-high reset
sel_in  input  1  peripheral selected for current bus cycle
data_addr_in  input  4  byte offset; bits [3:2] select register, bits [1:0] ignored
data_wr_in  input  32  write data
data_we_in  input  1  write enable, qualified by sel_in
data_rd_out  output  32  read data, registered
sw_in  input  NUM_SW  raw asynchronous switch pins
irq_out  output  1  level interrupt request (optional feature)

Behaviour:
- Reset (async assert, synchronous deassert handled upstream):
  - Clears sync flops, tick prescaler, per-bit counters, debounced state, RISE, FALL, CTRL.
  - data_rd_out=0, irq_out=0.
- Synchroniser: 2-flop per bit, sw_in -> s.
- Tick prescaler:
  - Counts 0..TICK_DIV-1, wraps.
  - tick=1 for one cycle when count==TICK_DIV-1.
  - First tick after reset occurs on cycle TICK_DIV.
- Per-bit debounce, evaluated only on tick; debounced state d, counter c (width clog2(DEBOUNCE_TICKS)+1):
  - s==d: c<=0.
  - s!=d and c==DEBOUNCE_TICKS-1: d<=s, c<=0; set RISE[i] if s=1, else set FALL[i].
  - otherwise: c<=c+1.
  - Any glitch returning to d before acceptance resets c; no flag is set.
- d resets to 0. A switch held high through reset therefore produces STATUS=1 and RISE=1 after debounce (defined, intended).
- Registers (offset / name / access):
  - 0x0 STATUS: RO, d.
  - 0x4 RISE: W1C sticky.
  - 0x8 FALL: W1C sticky.
  - 0xC CTRL: RW; bits [NUM_SW-1:0] irq mask.
  - Bits >= NUM_SW read 0 and ignore writes.
- Write: when sel_in & data_we_in, applies to the addressed register in that cycle.
  - W1C: flag <= (flag & ~data_wr_in) | set_event.
  - A set event and a clear of the same bit in the same cycle leave the bit SET.
- Read:
  - data_rd_out <= register[data_addr_in[3:2]] every cycle, regardless of sel_in or we; 1-cycle latency.
  - A read following a write in the next cycle returns the post-write value.
  - A read in the same cycle as a write returns the pre-write value.
- Write to STATUS is ignored.
- Reset mid-debounce discards progress; no flag survives.

Optional Feature:
SW_INPUT_IRQ_EN
- Defined:
  - CTRL implemented.
  - irq_out registered: irq_out <= |((RISE|FALL) & CTRL[NUM_SW-1:0]).
  - Deasserts the cycle after the last enabled flag clears.
- Undefined:
  - CTRL reads 0, writes ignored.
  - irq_out tied 0; mask logic absent.

Test Plan:
All scenarios use TICK_DIV=4, DEBOUNCE_TICKS=3.
1. Assert rst_in mid-run with flags set -> data_rd_out, irq_out, RISE, FALL, STATUS all 0 immediately (async); reads of 0x0/0x4/0x8/0xC return 0.
2. Set sw_in[0]=1 and hold -> STATUS=0x0001 and RISE=0x0001 no earlier than 3 ticks after sync, and within 2+4*4 cycles of the pin change; FALL=0.
3. Pulse sw_in[3]=1 for 6 cycles (at most 2 ticks) -> STATUS, RISE, FALL stay 0x0000.
4. With RISE=0x0003: write 0x0001 to 0x4 -> next read 0x0002. Write 0x0002 in the same cycle a new rise on bit 1 is accepted -> RISE stays 0x0002.
5. SW_INPUT_IRQ_EN defined: CTRL=0x0002, switch bit 1 1->0 debounced -> FALL=0x0002 and irq_out=1 one cycle later. Write 0x0002 to 0x8 -> irq_out=0 next cycle. Same stimulus with mask 0x0000 -> irq_out stays 0.
6. SW_INPUT_IRQ_EN undefined: write 0xFFFF to 0xC -> reads 0; irq_out constant 0 through scenario 5 stimulus.

Source files
------------

// File: rtl/sw_input_periph.sv
// sw_input_periph: memory-mapped switch input responder.
// Synchronises and debounces NUM_SW switch pins and keeps sticky edge flags.
// Register map (word offsets): 0x0 STATUS (RO), 0x4 RISE (W1C),
// 0x8 FALL (W1C), 0xC CTRL (RW irq mask).
// Optional macro SW_INPUT_IRQ_EN: implements CTRL and the irq_out level
// interrupt; without it CTRL reads 0 and irq_out is tied low.
module sw_input_periph #(
  parameter int NUM_SW         = 16,
  parameter int TICK_DIV       = 2000,
  parameter int DEBOUNCE_TICKS = 500
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              sel_in,
  input  logic [3:0]        data_addr_in,
  input  logic [31:0]       data_wr_in,
  input  logic              data_we_in,
  output logic [31:0]       data_rd_out,
  input  logic [NUM_SW-1:0] sw_in,
  output logic              irq_out
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_TICKS) + 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_TICKS - 1);

  logic [NUM_SW-1:0] s_p0;
  logic [NUM_SW-1:0] s_p1;
  logic [TW-1:0]     pre_cnt;
  logic              tick;
  logic [CW-1:0]     cnt [NUM_SW];
  logic [NUM_SW-1:0] sw_d;
  logic [NUM_SW-1:0] rise;
  logic [NUM_SW-1:0] fall;
  logic [NUM_SW-1:0] ctrl;
  logic [NUM_SW-1:0] rise_set;
  logic [NUM_SW-1:0] fall_set;
  logic [NUM_SW-1:0] wr_bits;
  logic              we_hit;
  logic              wr_rise;
  logic              wr_fall;
  logic              unused_ok;

  // Register contents are narrower than the bus; upper bits read as zero.
  function automatic logic [31:0] zext(input logic [NUM_SW-1:0] v);
    return 32'(v);
  endfunction

  assign we_hit    = sel_in & data_we_in;
  assign wr_rise   = we_hit && (data_addr_in[3:2] == 2'd1);
  assign wr_fall   = we_hit && (data_addr_in[3:2] == 2'd2);
  assign wr_bits   = data_wr_in[NUM_SW-1:0];
  assign tick      = (pre_cnt == TICK_LAST);
  // Byte-lane bits of the address and upper write bits carry no meaning here.
  assign unused_ok = ^{data_addr_in[1:0], data_wr_in};

  // Two-flop synchroniser for the asynchronous switch pins (stage p0 -> p1).
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      s_p0 <= '0;
      s_p1 <= '0;
    end else begin
      s_p0 <= sw_in;
      s_p1 <= s_p0;
    end
  end

  // Sample-tick prescaler: one-cycle tick every TICK_DIV clocks.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)    pre_cnt <= '0;
    else if (tick) pre_cnt <= '0;
    else           pre_cnt <= pre_cnt + 1'b1;
  end

  // Acceptance events: a changed input that has held for the full tick count.
  always_comb begin
    rise_set = '0;
    fall_set = '0;
    for (int i = 0; i < NUM_SW; i++) begin
      if (tick && (s_p1[i] != sw_d[i]) && (cnt[i] == CNT_LAST)) begin
        rise_set[i] = s_p1[i];
        fall_set[i] = ~s_p1[i];
      end
    end
  end

  // Per-bit debounce counters and accepted state; any return to d restarts.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sw_d <= '0;
      for (int i = 0; i < NUM_SW; i++) cnt[i] <= '0;
    end else if (tick) begin
      for (int i = 0; i < NUM_SW; i++) begin
        if (s_p1[i] == sw_d[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          sw_d[i] <= s_p1[i];
          cnt[i]  <= '0;
        end else begin
          cnt[i]  <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Sticky edge flags: write-one-to-clear, a same-cycle set event wins.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rise <= '0;
      fall <= '0;
    end else begin
      rise <= (rise & ~(wr_rise ? wr_bits : '0)) | rise_set;
      fall <= (fall & ~(wr_fall ? wr_bits : '0)) | fall_set;
    end
  end

`ifdef SW_INPUT_IRQ_EN
  logic wr_ctrl;
  assign wr_ctrl = we_hit && (data_addr_in[3:2] == 2'd3);

  // Interrupt mask register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)       ctrl <= '0;
    else if (wr_ctrl) ctrl <= wr_bits;
  end

  // Registered level interrupt from any enabled pending flag.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) irq_out <= 1'b0;
    else        irq_out <= |((rise | fall) & ctrl);
  end
`else
  assign ctrl    = '0;
  assign irq_out = 1'b0;
`endif

  // Registered read port: every cycle, pre-write contents of the addressed word.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      data_rd_out <= '0;
    end else begin
      case (data_addr_in[3:2])
        2'd0:    data_rd_out <= zext(sw_d);
        2'd1:    data_rd_out <= zext(rise);
        2'd2:    data_rd_out <= zext(fall);
        default: data_rd_out <= zext(ctrl);
      endcase
    end
  end

endmodule

// File: tb/tb_sw_input_periph.sv
// Testbench for sw_input_periph with TICK_DIV=4, DEBOUNCE_TICKS=3.
// A window-based behavioural model predicts read data and irq every cycle;
// directed reads pin the expected register values by hand.
module tb_sw_input_periph;

  localparam int NSW = 16;
  localparam int TD  = 4;
  localparam int DT  = 3;

  logic           clk_in = 1'b0;
  logic           rst_in = 1'b1;
  logic           sel_in = 1'b0;
  logic [3:0]     data_addr_in = '0;
  logic [31:0]    data_wr_in = '0;
  logic           data_we_in = 1'b0;
  logic [31:0]    data_rd_out;
  logic [NSW-1:0] sw_in = '0;
  logic           irq_out;

  int checks = 0;
  int errors = 0;

  sw_input_periph #(
    .NUM_SW(NSW), .TICK_DIV(TD), .DEBOUNCE_TICKS(DT)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .sel_in(sel_in),
    .data_addr_in(data_addr_in), .data_wr_in(data_wr_in),
    .data_we_in(data_we_in), .data_rd_out(data_rd_out),
    .sw_in(sw_in), .irq_out(irq_out)
  );

  always #5 clk_in = ~clk_in;

  // Behavioural model: a switch value is accepted once the last DT tick
  // samples all differ from the accepted state.
  logic [NSW-1:0] m_h1 = '0, m_h2 = '0, m_snow;
  logic [NSW-1:0] m_d = '0, m_rise = '0, m_fall = '0, m_ctrl = '0;
  logic [NSW-1:0] m_rset, m_fset, m_wm;
  logic [DT-1:0]  m_win [NSW];
  logic [31:0]    m_rd = '0;
  logic           m_irq = 1'b0;
  logic           m_tick;
  int             m_cyc = 0;

  function automatic logic [31:0] m_reg(input logic [1:0] a);
    case (a)
      2'd0:    return {16'h0, m_d};
      2'd1:    return {16'h0, m_rise};
      2'd2:    return {16'h0, m_fall};
      default: return {16'h0, m_ctrl};
    endcase
  endfunction

  // True when the coming clock edge will accept a change on bit b.
  function automatic bit m_accept_next(input int b);
    return ((m_cyc % TD) == TD - 1) &&
           ({m_win[b][DT-2:0], m_h2[b]} == {DT{~m_d[b]}});
  endfunction

  always @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      m_h1 = '0; m_h2 = '0; m_d = '0; m_rise = '0; m_fall = '0; m_ctrl = '0;
      for (int i = 0; i < NSW; i++) m_win[i] = '0;
      m_rd = '0; m_irq = 1'b0; m_cyc = 0;
    end else begin
      m_rd  = m_reg(data_addr_in[3:2]);
`ifdef SW_INPUT_IRQ_EN
      m_irq = |((m_rise | m_fall) & m_ctrl);
`else
      m_irq = 1'b0;
`endif
      m_snow = m_h2; m_h2 = m_h1; m_h1 = sw_in;
      m_tick = ((m_cyc % TD) == TD - 1);
      m_cyc++;
      m_rset = '0; m_fset = '0;
      if (m_tick) begin
        for (int i = 0; i < NSW; i++) begin
          m_win[i] = {m_win[i][DT-2:0], m_snow[i]};
          if (m_win[i] == {DT{~m_d[i]}}) begin
            m_d[i] = m_snow[i];
            if (m_snow[i]) m_rset[i] = 1'b1;
            else           m_fset[i] = 1'b1;
          end
        end
      end
      m_wm = data_wr_in[NSW-1:0];
      if (sel_in && data_we_in) begin
        case (data_addr_in[3:2])
          2'd1: m_rise = m_rise & ~m_wm;
          2'd2: m_fall = m_fall & ~m_wm;
`ifdef SW_INPUT_IRQ_EN
          2'd3: m_ctrl = m_wm;
`endif
          default: ;
        endcase
      end
      m_rise = m_rise | m_rset;
      m_fall = m_fall | m_fset;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic rd_chk(input string nm, input logic [3:0] a, input logic [31:0] exp);
    @(negedge clk_in);
    data_addr_in = a;
    @(negedge clk_in);
    chk(nm, data_rd_out, exp);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] v, output logic [31:0] rd_pre);
    @(negedge clk_in);
    sel_in = 1'b1; data_we_in = 1'b1; data_addr_in = a; data_wr_in = v;
    @(negedge clk_in);
    rd_pre = data_rd_out;
    sel_in = 1'b0; data_we_in = 1'b0; data_wr_in = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  logic [31:0] rdv;
  bit          found;

  initial begin
    fork
      forever begin
        @(negedge clk_in);
        chk("model_rd", data_rd_out, m_rd);
        chk("model_irq", {31'b0, irq_out}, {31'b0, m_irq});
      end
    join_none

    idle(3);
    chk("reset_rd", data_rd_out, 32'h0);
    chk("reset_irq", {31'b0, irq_out}, 32'h0);
    rst_in = 1'b0;

    // Short pulse on bit 3: never accepted
    @(negedge clk_in);
    sw_in[3] = 1'b1;
    idle(6);
    sw_in[3] = 1'b0;
    idle(20);
    rd_chk("glitch_status", 4'h0, 32'h0);
    rd_chk("glitch_rise", 4'h4, 32'h0);
    rd_chk("glitch_fall", 4'h8, 32'h0);

    // Held rise on bit 0
    @(negedge clk_in);
    sw_in[0] = 1'b1;
    rd_chk("rise0_early", 4'h0, 32'h0);
    idle(14);
    rd_chk("rise0_status", 4'h0, 32'h1);
    rd_chk("rise0_rise", 4'h4, 32'h1);
    rd_chk("rise0_fall", 4'h8, 32'h0);

    // RISE=3, W1C clear of bit 0
    @(negedge clk_in);
    sw_in[1] = 1'b1;
    idle(20);
    rd_chk("rise01", 4'h4, 32'h3);
    wr(4'h4, 32'h1, rdv);
    chk("rd_same_cycle_prewrite", rdv, 32'h3);
    rd_chk("w1c_rise", 4'h4, 32'h2);
    wr(4'h0, 32'hFFFF, rdv);
    rd_chk("status_ro", 4'h0, 32'h3);

    // Clear of bit 1 collides with a fresh rise on bit 1
    sw_in[1] = 1'b0;
    idle(20);
    rd_chk("fall1", 4'h8, 32'h2);
    sw_in[1] = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 60 && !found; k++) begin
      @(negedge clk_in);
      if (m_accept_next(1)) found = 1'b1;
    end
    chk("accept_wait", {31'b0, found}, 32'h1);
    sel_in = 1'b1; data_we_in = 1'b1; data_addr_in = 4'h4; data_wr_in = 32'h2;
    @(negedge clk_in);
    sel_in = 1'b0; data_we_in = 1'b0; data_wr_in = '0;
    rd_chk("collide_rise", 4'h4, 32'h2);

    // Clear all flags
    wr(4'h4, 32'hFFFF, rdv);
    wr(4'h8, 32'hFFFF, rdv);
    rd_chk("clr_rise", 4'h4, 32'h0);
    rd_chk("clr_fall", 4'h8, 32'h0);

`ifdef SW_INPUT_IRQ_EN
    wr(4'hC, 32'h0002, rdv);
    rd_chk("ctrl_rw", 4'hC, 32'h2);
    chk("irq_idle", {31'b0, irq_out}, 32'h0);
    sw_in[1] = 1'b0;
    idle(20);
    rd_chk("irq_fall", 4'h8, 32'h2);
    chk("irq_set", {31'b0, irq_out}, 32'h1);
    wr(4'h8, 32'h0002, rdv);
    @(negedge clk_in);
    chk("irq_cleared", {31'b0, irq_out}, 32'h0);
    wr(4'hC, 32'h0000, rdv);
    sw_in[1] = 1'b1;
    idle(20);
    sw_in[1] = 1'b0;
    idle(20);
    rd_chk("mask0_fall", 4'h8, 32'h2);
    chk("mask0_irq", {31'b0, irq_out}, 32'h0);
`else
    wr(4'hC, 32'hFFFF, rdv);
    rd_chk("ctrl_absent", 4'hC, 32'h0);
    sw_in[1] = 1'b0;
    idle(20);
    rd_chk("noirq_fall", 4'h8, 32'h2);
    chk("noirq_irq", {31'b0, irq_out}, 32'h0);
    wr(4'h8, 32'h0002, rdv);
    sw_in[1] = 1'b1;
    idle(20);
    rd_chk("noirq_rise", 4'h4, 32'h2);
    chk("noirq_irq2", {31'b0, irq_out}, 32'h0);
`endif

    // Asynchronous reset mid-cycle with flags pending
    data_addr_in = 4'h4;
    @(negedge clk_in);
    #1;
    sw_in = '0;
    rst_in = 1'b1;
    #1;
    chk("async_rst_rd", data_rd_out, 32'h0);
    chk("async_rst_irq", {31'b0, irq_out}, 32'h0);
    idle(2);
    rst_in = 1'b0;
    rd_chk("post_rst_status", 4'h0, 32'h0);
    rd_chk("post_rst_rise", 4'h4, 32'h0);
    rd_chk("post_rst_fall", 4'h8, 32'h0);
    rd_chk("post_rst_ctrl", 4'hC, 32'h0);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
